// File: rtl/and4_b_unit.sv
// ---------------------------------------------------------------------------
// and4_b_unit
// Four-input bitwise AND with a zero-latency combinational result, a
// registered valid-qualified copy and a saturating counter of captured
// all-ones results.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   a,b,c,d   in   WIDTH  operands
//   in_valid  in   1      operands valid; qualifies the registered path only
//   o         out  WIDTH  combinational a & b & c & d
//   o_q       out  WIDTH  registered result (holds when in_valid=0)
//   out_valid out  1      o_q was captured on the previous edge
//   all_ones  out  1      captured result was all ones (and out_valid=1)
//   hit_cnt   out  CNT_W  saturating count of captured all-ones results
// ---------------------------------------------------------------------------
module and4_b_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic             out_valid,
    output logic             all_ones,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // True when every bit of the operand is set.
    function automatic logic is_all_ones(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b1}});
    endfunction

    logic [WIDTH-1:0] and_s;
    logic             hit_s;

    logic [WIDTH-1:0] o_q_r;
    logic             out_valid_r;
    logic             all_ones_r;
    logic [CNT_W-1:0] hit_cnt_r;

    logic [WIDTH-1:0] o_q_nxt_s;
    logic             out_valid_nxt_s;
    logic             all_ones_nxt_s;
    logic [CNT_W-1:0] hit_cnt_nxt_s;

    // Combinational AND of the four operands; independent of clock and reset.
    always_comb begin
        and_s = a & b & c & d;
        hit_s = in_valid & is_all_ones(and_s);
    end

    assign o = and_s;

    // Next-state for the registered path and the saturating hit counter.
    always_comb begin
        o_q_nxt_s       = o_q_r;
        out_valid_nxt_s = 1'b0;
        all_ones_nxt_s  = 1'b0;
        hit_cnt_nxt_s   = hit_cnt_r;
        if (in_valid) begin
            o_q_nxt_s       = and_s;
            out_valid_nxt_s = 1'b1;
            all_ones_nxt_s  = is_all_ones(and_s);
        end else begin
            o_q_nxt_s       = o_q_r;
            out_valid_nxt_s = 1'b0;
            all_ones_nxt_s  = 1'b0;
        end
        // Counter sticks at its maximum instead of wrapping.
        if (hit_s && (hit_cnt_r != CNT_MAX)) begin
            hit_cnt_nxt_s = hit_cnt_r + CNT_W'(1);
        end else begin
            hit_cnt_nxt_s = hit_cnt_r;
        end
    end

    // State registers; asynchronous reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            all_ones_r  <= 1'b0;
            hit_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            o_q_r       <= o_q_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            all_ones_r  <= all_ones_nxt_s;
            hit_cnt_r   <= hit_cnt_nxt_s;
        end
    end

    assign o_q       = o_q_r;
    assign out_valid = out_valid_r;
    assign all_ones  = all_ones_r;
    assign hit_cnt   = hit_cnt_r;

endmodule

// File: tb/tb_and4_b_unit.sv
// ---------------------------------------------------------------------------
// tb_and4_b_unit
// Three instances share one stimulus: u1 (WIDTH=1, CNT_W=8), u2 (WIDTH=1,
// CNT_W=2) and u4 (WIDTH=4, CNT_W=8). The 1-bit instances see bit 0 of the
// 4-bit operand buses. A history of captured products drives a model that
// the compare process checks every cycle; directed steps add literal checks.
// ---------------------------------------------------------------------------
module tb_and4_b_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic [3:0] c = 4'h0;
    logic [3:0] d = 4'h0;
    logic       in_valid = 1'b0;

    logic       o1, oq1, ov1, ao1;
    logic [7:0] hc1;
    logic       o2, oq2, ov2, ao2;
    logic [1:0] hc2;
    logic [3:0] o4, oq4;
    logic       ov4, ao4;
    logic [7:0] hc4;

    int checks = 0;
    int errors = 0;

    and4_b_unit #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
        .in_valid(in_valid), .o(o1), .o_q(oq1), .out_valid(ov1),
        .all_ones(ao1), .hit_cnt(hc1));

    and4_b_unit #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
        .in_valid(in_valid), .o(o2), .o_q(oq2), .out_valid(ov2),
        .all_ones(ao2), .hit_cnt(hc2));

    and4_b_unit #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .o(o4), .o_q(oq4), .out_valid(ov4),
        .all_ones(ao4), .hit_cnt(hc4));

    // 40-unit clock period, rising edges at 20, 60, 100, ...
    always #20 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: history of every product captured since the last reset, plus
    // whether the most recent edge captured.
    logic [3:0] cap_mem [0:255];
    int         n_cap = 0;
    logic       last_v = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cap  <= 0;
            last_v <= 1'b0;
        end else begin
            last_v <= in_valid;
            if (in_valid) begin
                cap_mem[n_cap[7:0]] <= a & b & c & d;
                n_cap               <= n_cap + 1;
            end
        end
    end

    function automatic int min_i(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic compare_all();
        int   hits1;
        int   hits4;
        logic [3:0] last;
        logic [3:0] prod;
        hits1 = 0;
        hits4 = 0;
        last  = 4'h0;
        for (int j = 0; j < n_cap; j++) begin
            if (cap_mem[j][0]) hits1++;
            if (cap_mem[j] == 4'hF) hits4++;
        end
        if (n_cap > 0) last = cap_mem[n_cap - 1];
        prod = a & b & c & d;
        check("u1.o", int'(o1), int'(prod[0]));
        check("u4.o", int'(o4), int'(prod));
        check("u1.o_q", int'(oq1), int'(last[0]));
        check("u2.o_q", int'(oq2), int'(last[0]));
        check("u4.o_q", int'(oq4), int'(last));
        check("u1.out_valid", int'(ov1), int'(last_v));
        check("u4.out_valid", int'(ov4), int'(last_v));
        check("u1.all_ones", int'(ao1), int'(last_v && last[0]));
        check("u2.all_ones", int'(ao2), int'(last_v && last[0]));
        check("u4.all_ones", int'(ao4), int'(last_v && (last == 4'hF)));
        check("u1.hit_cnt", int'(hc1), min_i(hits1, 255));
        check("u2.hit_cnt", int'(hc2), min_i(hits1, 3));
        check("u4.hit_cnt", int'(hc4), min_i(hits4, 255));
    endtask

    // Compare process: one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        compare_all();
    end

    task automatic set_all(input logic [3:0] v);
        a = v;
        b = v;
        c = v;
        d = v;
    endtask

    int sat_exp [0:5] = '{1, 2, 3, 3, 3, 3};

    initial begin
        logic [3:0] v;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst u1.o_q", int'(oq1), 0);
        check("rst u1.out_valid", int'(ov1), 0);
        check("rst u1.hit_cnt", int'(hc1), 0);
        rst_n = 1'b1;

        // Truth-table sweep with in_valid=0, one time unit per vector.
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            a = {4{v[3]}};
            b = {4{v[2]}};
            c = {4{v[1]}};
            d = {4{v[0]}};
            #1;
            check("sweep0 u1.o", int'(o1), (i == 15) ? 1 : 0);
            check("sweep0 u4.o", int'(o4), (i == 15) ? 15 : 0);
        end
        @(posedge clk);
        #1;
        check("sweep0 u1.o_q", int'(oq1), 0);

        // Same sweep captured on successive clocks.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v = 4'(i);
            a = {4{v[3]}};
            b = {4{v[2]}};
            c = {4{v[1]}};
            d = {4{v[0]}};
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check("sweep1 u1.o_q", int'(oq1), 1);
        check("sweep1 u1.all_ones", int'(ao1), 1);
        check("sweep1 u1.hit_cnt", int'(hc1), 1);
        check("sweep1 u4.hit_cnt", int'(hc4), 1);

        // Reset between edges with a capture pending.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst u1.o_q", int'(oq1), 0);
        check("midrst u1.out_valid", int'(ov1), 0);
        check("midrst u1.all_ones", int'(ao1), 0);
        check("midrst u1.hit_cnt", int'(hc1), 0);
        check("midrst u4.o_q", int'(oq4), 0);
        check("midrst u1.o", int'(o1), 1);
        a = 4'h0;
        #1;
        check("midrst u1.o tracks", int'(o1), 0);
        check("midrst u4.o tracks", int'(o4), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the 2-bit counter.
        @(negedge clk);
        set_all(4'hF);
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("sat u2.hit_cnt", int'(hc2), sat_exp[k]);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // WIDTH=4: all_ones needs every bit.
        @(negedge clk);
        a = 4'hF; b = 4'hF; c = 4'hF; d = 4'hE;
        in_valid = 1'b1;
        #1;
        check("w4 o=E", int'(o4), 14);
        @(posedge clk);
        #1;
        check("w4 o_q=E", int'(oq4), 14);
        check("w4 all_ones=0", int'(ao4), 0);
        @(negedge clk);
        d = 4'hF;
        #1;
        check("w4 o=F", int'(o4), 15);
        @(posedge clk);
        #1;
        check("w4 o_q=F", int'(oq4), 15);
        check("w4 all_ones=1", int'(ao4), 1);
        @(negedge clk);
        in_valid = 1'b0;

        // in_valid gap: o_q holds, out_valid follows.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        set_all(4'hF);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("gap ov#1", int'(ov1), 1);
        check("gap oq#1", int'(oq1), 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("gap ov#2", int'(ov1), 0);
        check("gap oq#2", int'(oq1), 1);
        check("gap ao#2", int'(ao1), 0);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("gap ov#3", int'(ov1), 1);
        check("gap hit_cnt", int'(hc1), 2);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
